pzbcm_slicer_channel_scheduler: RTL and testbench

- Shares one pipelined, non-backpressured sliced channel between N requesters.
- Round-robin arbitration picks one requester per cycle and launches its payload as a single registered beat (id + data) into the channel.
- Credit-based flow control: a launch consumes one credit, the far-end receiver returns credits, and no launch happens at zero credit, so the receive buffer can never overflow despite the channel's fixed latency.

---
 rtl/pzbcm_slicer_channel_scheduler.sv | 115 +++++++++++
 tb/tb_pzbcm_slicer_channel_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pzbcm_slicer_channel_scheduler.sv
// Round-robin, credit-gated scheduler that shares one non-backpressured sliced
// channel between N requesters, launching one registered id+data beat per grant.
module pzbcm_slicer_channel_scheduler #(
    parameter  int N       = 4,
    parameter  int WIDTH   = 32,
    parameter  int CREDITS = 8,
    localparam int CW      = $clog2(CREDITS + 1),
    localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N-1:0]              i_request,
    input  logic [N-1:0][WIDTH-1:0]   i_data,
    output logic [N-1:0]              o_grant,
    output logic                      o_valid,
    output logic [IDW-1:0]            o_id,
    output logic [WIDTH-1:0]          o_data,
    input  logic                      i_credit_return,
    output logic [CW-1:0]             o_credits,
    output logic                      o_credit_error
);

    logic [IDW-1:0]   ptr_q,     ptr_d;
    logic             valid_q,   valid_d;
    logic [IDW-1:0]   id_q,      id_d;
    logic [WIDTH-1:0] data_q,    data_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic             err_q,     err_d;

    logic [IDW-1:0]   scan_idx [N];
    logic [N-1:0]     scan_req;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;

    // Scan slot gi looks at requester (ptr + gi) mod N; the sum is at most 2N-2.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_scan
            logic [IDW:0] sum;
            assign sum          = {1'b0, ptr_q} + (IDW+1)'(gi);
            assign scan_idx[gi] = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
            assign scan_req[gi] = i_request[scan_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < N; off++) begin
            if (!grant_any && scan_req[off]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx[off];
            end
        end
        // Gate on the registered count: a return arriving at zero only helps next cycle.
        if (credits_q == '0) begin
            grant_any = 1'b0;
            grant_idx = '0;
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_grant
            assign o_grant[gi] = grant_any && (grant_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        ptr_d     = ptr_q;
        valid_d   = grant_any;
        id_d      = id_q;
        data_d    = data_q;
        credits_d = credits_q;
        err_d     = err_q;
        if (grant_any) begin
            id_d   = grant_idx;
            data_d = i_data[grant_idx];
            ptr_d  = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
        if (grant_any && !i_credit_return) begin
            credits_d = credits_q - 1'b1;
        end else if (!grant_any && i_credit_return) begin
            if (credits_q == CW'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            id_q      <= '0;
            data_q    <= '0;
            credits_q <= CW'(CREDITS);
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            data_q    <= data_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_id           = id_q;
    assign o_data         = data_q;
    assign o_credits      = credits_q;
    assign o_credit_error = err_q;

endmodule

// File: tb/tb_pzbcm_slicer_channel_scheduler.sv
// Bench for the channel scheduler: an N=4 and an N=3 instance, each checked every
// cycle against a queue-free behavioural model, plus directed literal scenarios.
module tb_pzbcm_slicer_channel_scheduler;
    localparam int W  = 32;
    localparam int CR = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        req0 = '0;
    logic [3:0][W-1:0] data0 = '0;
    logic              ret0 = 1'b0;
    logic [3:0]        g0;
    logic              v0;
    logic [1:0]        id0;
    logic [W-1:0]      d0;
    logic [3:0]        c0;
    logic              e0;

    logic [2:0]        req1 = '0;
    logic [2:0][W-1:0] data1 = '0;
    logic              ret1 = 1'b0;
    logic [2:0]        g1;
    logic              v1;
    logic [1:0]        id1;
    logic [W-1:0]      d1;
    logic [3:0]        c1;
    logic              e1;

    pzbcm_slicer_channel_scheduler #(.N(4), .WIDTH(W), .CREDITS(CR)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req0), .i_data(data0),
        .o_grant(g0), .o_valid(v0), .o_id(id0), .o_data(d0),
        .i_credit_return(ret0), .o_credits(c0), .o_credit_error(e0)
    );

    pzbcm_slicer_channel_scheduler #(.N(3), .WIDTH(W), .CREDITS(CR)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req1), .i_data(data1),
        .o_grant(g1), .o_valid(v1), .o_id(id1), .o_data(d1),
        .i_credit_return(ret1), .o_credits(c1), .o_credit_error(e1)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model state per unit (0: N=4, 1: N=3).
    int          m_ptr   [2] = '{0, 0};
    int          m_cred  [2] = '{CR, CR};
    bit          m_err   [2] = '{0, 0};
    bit          m_valid [2] = '{0, 0};
    int          m_id    [2] = '{0, 0};
    logic [W-1:0] m_data [2] = '{0, 0};

    // First requesting index at or after ptr, wrapping mod n; -1 if none or out of credit.
    function automatic int exp_grant(int n, int ptr, int cred, logic [3:0] req);
        if (cred == 0) return -1;
        for (int off = 0; off < n; off++) begin
            int k = (ptr + off) % n;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(int g);
        logic [3:0] v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic model_step(int u, int n, logic [3:0] req, logic [3:0][W-1:0] dat, logic ret);
        int g = exp_grant(n, m_ptr[u], m_cred[u], req);
        m_valid[u] = (g >= 0);
        if (g >= 0) begin
            m_id[u]   = g;
            m_data[u] = dat[g];
            m_ptr[u]  = (g + 1) % n;
        end
        if (g >= 0 && !ret)       m_cred[u] = m_cred[u] - 1;
        else if (g < 0 && ret) begin
            if (m_cred[u] == CR)  m_err[u] = 1'b1;
            else                  m_cred[u] = m_cred[u] + 1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) begin
                m_ptr[u] = 0; m_cred[u] = CR; m_err[u] = 0;
                m_valid[u] = 0; m_id[u] = 0; m_data[u] = '0;
            end
        end else begin
            model_step(0, 4, req0, data0, ret0);
            model_step(1, 3, {1'b0, req1}, {{W{1'b0}}, data1}, ret1);
        end
    end

    always @(negedge clk) begin
        chk("grant0",   {60'b0, g0}, {60'b0, onehot(exp_grant(4, m_ptr[0], m_cred[0], req0))});
        chk("valid0",   64'(v0),  64'(m_valid[0]));
        chk("id0",      64'(id0), 64'(m_id[0]));
        chk("data0",    64'(d0),  64'(m_data[0]));
        chk("credits0", 64'(c0),  64'(m_cred[0]));
        chk("err0",     64'(e0),  64'(m_err[0]));
        chk("grant1",   {61'b0, g1}, {60'b0, onehot(exp_grant(3, m_ptr[1], m_cred[1], {1'b0, req1}))});
        chk("valid1",   64'(v1),  64'(m_valid[1]));
        chk("id1",      64'(id1), 64'(m_id[1]));
        chk("data1",    64'(d1),  64'(m_data[1]));
        chk("credits1", 64'(c1),  64'(m_cred[1]));
        chk("err1",     64'(e1),  64'(m_err[1]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_id",    64'(id0), 64'd0);
        chk("rst_data",  64'(d0), 64'd0);
        chk("rst_cred",  64'(c0), 64'd8);
        chk("rst_err",   64'(e0), 64'd0);
        rst_n = 1'b1;

        // Single request on index 2
        req0 = 4'b0100; data0[2] = 32'hA5;
        @(negedge clk); chk("t1_grant", 64'(g0), 64'h4);
        tick(); req0 = '0;
        chk("t1_valid", 64'(v0), 64'd1);
        chk("t1_id",    64'(id0), 64'd2);
        chk("t1_data",  64'(d0), 64'hA5);
        chk("t1_cred",  64'(c0), 64'd7);

        // All requesting, credits drain 8 -> 0 in round-robin order
        do_reset();
        req0 = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("t2_grant", 64'(g0), 64'(1 << (i % 4)));
            tick();
            chk("t2_id",   64'(id0), 64'(i % 4));
            chk("t2_cred", 64'(c0), 64'(7 - i));
        end
        @(negedge clk); chk("t2_nogrant", 64'(g0), 64'd0);
        tick(); chk("t2_novalid", 64'(v0), 64'd0);

        // Return at zero credit does not enable a same-cycle grant
        ret0 = 1'b1;
        @(negedge clk); chk("t3_nogrant", 64'(g0), 64'd0);
        tick(); ret0 = 1'b0;
        chk("t3_cred1", 64'(c0), 64'd1);
        @(negedge clk); chk("t3_grant", 64'(g0), 64'd1);
        tick(); req0 = '0;
        chk("t3_cred0", 64'(c0), 64'd0);
        chk("t3_id",    64'(id0), 64'd0);

        // Simultaneous grant and return keeps the count
        ret0 = 1'b1;
        repeat (3) tick();
        chk("t4_cred3", 64'(c0), 64'd3);
        req0 = 4'b0010;
        @(negedge clk); chk("t4_grant", 64'(g0), 64'h2);
        tick(); req0 = '0; ret0 = 1'b0;
        chk("t4_cred", 64'(c0), 64'd3);
        chk("t4_id",   64'(id0), 64'd1);

        // Over-return at full credit saturates and sets the sticky error
        ret0 = 1'b1;
        repeat (5) tick();
        ret0 = 1'b0;
        chk("t5_full", 64'(c0), 64'd8);
        chk("t5_noerr", 64'(e0), 64'd0);
        ret0 = 1'b1; tick(); ret0 = 1'b0;
        chk("t5_sat", 64'(c0), 64'd8);
        chk("t5_err", 64'(e0), 64'd1);
        repeat (3) tick();
        chk("t5_sticky", 64'(e0), 64'd1);
        do_reset();
        chk("t5_errclr", 64'(e0), 64'd0);

        // N=3 wrap: move pointer to 2, then 101 alternates 2,0,2
        req1 = 3'b010;
        @(negedge clk); chk("t6_g1", 64'(g1), 64'h2);
        tick(); req1 = 3'b101;
        @(negedge clk); chk("t6_g2", 64'(g1), 64'h4);
        tick();
        @(negedge clk); chk("t6_g0", 64'(g1), 64'h1);
        tick();
        @(negedge clk); chk("t6_g2b", 64'(g1), 64'h4);
        tick();
        chk("t6_id", 64'(id1), 64'd2);
        rst_n = 1'b0; #1;
        chk("t6_rst_valid", 64'(v1), 64'd0);
        chk("t6_rst_cred",  64'(c1), 64'd8);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); chk("t6_after_rst", 64'(g1), 64'h1);
        tick(); req1 = '0;
        chk("t6_after_id", 64'(id1), 64'd0);

        // Randomized traffic; requests stay up until granted
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) rst_n = 1'b0;
            if (i == 1502) rst_n = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (m_valid[0] && m_id[0] == b) req0[b] = 1'b0;
                else if (!req0[b] && $urandom_range(2) == 0) req0[b] = 1'b1;
                data0[b] = $urandom;
            end
            for (int b = 0; b < 3; b++) begin
                if (m_valid[1] && m_id[1] == b) req1[b] = 1'b0;
                else if (!req1[b] && $urandom_range(2) == 0) req1[b] = 1'b1;
                data1[b] = $urandom;
            end
            ret0 = ($urandom_range(9) < 3);
            ret1 = ($urandom_range(9) < 4);
            tick();
        end
        req0 = '0; req1 = '0; ret0 = 1'b0; ret1 = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
